queue_arb: RTL and testbench

- Multi-channel successor to the single-channel valid/ready queue.
- CHANS independent FIFOs, each with its own valid/ready input, merge through a round-robin arbiter onto one valid/ready output tagged with a channel id.
- Adds true full-depth storage, non-power-of-two depth, per-channel flush, level and almost-full outputs, and a selectable registered output stage.
- Sits between multiple producers and one shared consumer.

---
 rtl/queue_pkg.sv | 24 ++
 rtl/queue_fifo.sv | 68 ++++++
 rtl/queue_arb.sv | 131 +++++++++++++
 tb/tb_queue_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared helpers for the multi-channel queue: pointer wrap, width helpers, id/count types.
// Combinational only; no latency or backpressure of its own.
package queue_pkg;

    localparam int CHANS_DEF = 4;
    localparam int DEPTH_DEF = 8;
    localparam int CIDX      = $clog2(CHANS_DEF);
    localparam int CNTW      = $clog2(DEPTH_DEF + 1);

    typedef logic [CNTW-1:0] cnt_t;
    typedef logic [CIDX-1:0] chan_t;

    // Folds val back into [min, max]; it is used for single-step increments,
    // so a single correction is enough and no power-of-two range is needed.
    function automatic int wrap(input int val, input int min, input int max);
        if (val > max)
            return val - (max - min + 1);
        else if (val < min)
            return val + (max - min + 1);
        else
            return val;
    endfunction

endpackage

// File: rtl/queue_fifo.sv
// Single-channel full-depth FIFO with flush; head is visible the cycle after the push edge.
// Backpressure: the caller gates push on !full and pop on !empty; flush discards both.
module queue_fifo
    import queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 8,
    parameter int AFULL = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [BITS-1:0]              wr_value,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [BITS-1:0]              head,
    output logic                         full,
    output logic                         empty,
    output logic                         afull
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int LW   = $clog2(DEPTH + 1);

    logic [BITS-1:0] mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= PTRW'(wrap(int'(wr_ptr) + 1, 0, DEPTH - 1));
            if (do_pop)
                rd_ptr <= PTRW'(wrap(int'(rd_ptr) + 1, 0, DEPTH - 1));
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; count and pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wr_value;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign afull = (count >= LW'(AFULL));

endmodule

// File: rtl/queue_arb.sv
// CHANS FIFOs merged round-robin onto one valid/ready output tagged with the source channel.
// Latency 1 cycle push-to-visible (+1 with OUT_REG); s_ready drops only when a channel is full.
module queue_arb
    import queue_pkg::*;
#(
    parameter int CHANS   = 4,
    parameter int DEPTH   = 8,
    parameter int BITS    = 8,
    parameter int OUT_REG = 0,
    parameter int AFULL   = 6
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [CHANS*BITS-1:0]              s_value,
    input  logic [CHANS-1:0]                   s_valid,
    output logic [CHANS-1:0]                   s_ready,
    input  logic [CHANS-1:0]                   flush,
    output logic [BITS-1:0]                    m_value,
    output logic [$clog2(CHANS)-1:0]           m_chan,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [CHANS*$clog2(DEPTH+1)-1:0]   level,
    output logic [CHANS-1:0]                   afull
);

    localparam int CW = $clog2(CHANS);
    localparam int LW = $clog2(DEPTH + 1);

    logic [LW-1:0]   count [CHANS];
    logic [BITS-1:0] head  [CHANS];
    logic [CHANS-1:0] full;
    logic [CHANS-1:0] empty;
    logic [CHANS-1:0] elig;
    logic [CHANS-1:0] pop;
    logic [CW-1:0]    rr;
    logic [CW-1:0]    gsel;
    logic [CW-1:0]    sel;
    logic [CW-1:0]    lock_chan;
    logic             locked;
    logic             found;
    logic             pop_any;

    for (genvar c = 0; c < CHANS; c++) begin : g_ch
        assign s_ready[c]          = ~reset & ~full[c];
        assign elig[c]             = ~empty[c] & ~flush[c];
        assign pop[c]              = pop_any & (sel == CW'(c));
        assign level[c*LW +: LW]   = count[c];

        queue_fifo #(
            .DEPTH (DEPTH),
            .BITS  (BITS),
            .AFULL (AFULL)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .push     (s_valid[c] & s_ready[c]),
            .pop      (pop[c]),
            .flush    (flush[c]),
            .wr_value (s_value[c*BITS +: BITS]),
            .count    (count[c]),
            .head     (head[c]),
            .full     (full[c]),
            .empty    (empty[c]),
            .afull    (afull[c])
        );
    end

    // First eligible channel strictly after rr, searching cyclically.
    always_comb begin
        gsel  = '0;
        found = 1'b0;
        for (int i = 1; i <= CHANS; i++) begin
            if (!found && elig[CW'(wrap(int'(rr) + i, 0, CHANS - 1))]) begin
                gsel  = CW'(wrap(int'(rr) + i, 0, CHANS - 1));
                found = 1'b1;
            end
        end
    end

    assign sel = (locked && elig[lock_chan]) ? lock_chan : gsel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr <= CW'(CHANS - 1);
        else if (pop_any)
            rr <= sel;
    end

    if (OUT_REG == 0) begin : g_comb
        assign pop_any = m_valid & m_ready;
        assign m_valid = |elig;
        assign m_value = m_valid ? head[sel] : '0;
        assign m_chan  = m_valid ? sel : '0;

        // A stalled offer pins the grant so the consumer sees a stable item.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                locked    <= 1'b0;
                lock_chan <= '0;
            end else begin
                locked <= m_valid & ~m_ready;
                if (m_valid & ~m_ready)
                    lock_chan <= sel;
            end
        end
    end else begin : g_reg
        logic load;

        assign load      = (~m_valid | m_ready) & (|elig);
        assign pop_any   = load;
        assign locked    = 1'b0;
        assign lock_chan = '0;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                m_valid <= 1'b0;
                m_value <= '0;
                m_chan  <= '0;
            end else if (load) begin
                m_valid <= 1'b1;
                m_value <= head[sel];
                m_chan  <= sel;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_value <= '0;
                m_chan  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_queue_arb.sv
// Directed bench for queue_arb: combinational (a_) and registered (b_) output instances,
// both CHANS=4, DEPTH=5, AFULL=4, with per-instance scoreboards of expected outputs.
module tb_queue_arb;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] value;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] a_s_value, b_s_value;
    logic [3:0]  a_s_valid, b_s_valid;
    logic [3:0]  a_s_ready, b_s_ready;
    logic [3:0]  a_flush, b_flush;
    logic [7:0]  a_m_value, b_m_value;
    logic [1:0]  a_m_chan, b_m_chan;
    logic        a_m_valid, b_m_valid;
    logic        a_m_ready, b_m_ready;
    logic [11:0] a_level, b_level;
    logic [3:0]  a_afull, b_afull;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    queue_arb #(.CHANS(4), .DEPTH(5), .BITS(8), .OUT_REG(0), .AFULL(4)) dut_a (
        .clock(clock), .reset(reset), .s_value(a_s_value), .s_valid(a_s_valid),
        .s_ready(a_s_ready), .flush(a_flush), .m_value(a_m_value), .m_chan(a_m_chan),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .level(a_level), .afull(a_afull)
    );

    queue_arb #(.CHANS(4), .DEPTH(5), .BITS(8), .OUT_REG(1), .AFULL(4)) dut_b (
        .clock(clock), .reset(reset), .s_value(b_s_value), .s_valid(b_s_valid),
        .s_ready(b_s_ready), .flush(b_flush), .m_value(b_m_value), .m_chan(b_m_chan),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .level(b_level), .afull(b_afull)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input int ch, input int v);
        exp_t e;
        e.chan  = 2'(ch);
        e.value = 8'(v);
        return e;
    endfunction

    function automatic logic [2:0] lv(input logic [11:0] l, input int c);
        return l[c*3 +: 3];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares every output handshake against the head of the matching scoreboard.
    task automatic cycle();
        exp_t e;
        @(negedge clock);
        if (a_m_valid && a_m_ready) begin
            chk("a_out_expected", 32'(sb_a.size() != 0), 1);
            if (sb_a.size() != 0) begin
                e = sb_a.pop_front();
                chk("a_out_chan", 32'(a_m_chan), 32'(e.chan));
                chk("a_out_value", 32'(a_m_value), 32'(e.value));
            end
        end
        if (b_m_valid && b_m_ready) begin
            chk("b_out_expected", 32'(sb_b.size() != 0), 1);
            if (sb_b.size() != 0) begin
                e = sb_b.pop_front();
                chk("b_out_chan", 32'(b_m_chan), 32'(e.chan));
                chk("b_out_value", 32'(b_m_value), 32'(e.value));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_s_value = '0; a_s_valid = '0; a_flush = '0; a_m_ready = 1'b0;
        b_s_value = '0; b_s_valid = '0; b_flush = '0; b_m_ready = 1'b0;
        #12;
        chk("rst_a_m_valid", 32'(a_m_valid), 0);
        chk("rst_a_m_value", 32'(a_m_value), 0);
        chk("rst_a_m_chan", 32'(a_m_chan), 0);
        chk("rst_a_level", 32'(a_level), 0);
        chk("rst_a_afull", 32'(a_afull), 0);
        chk("rst_a_s_ready", 32'(a_s_ready), 0);
        chk("rst_b_m_valid", 32'(b_m_valid), 0);
        chk("rst_b_s_ready", 32'(b_s_ready), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rel_a_s_ready", 32'(a_s_ready), 32'hF);

        // Single item on channel 2
        a_s_value[2*8 +: 8] = 8'hA1;
        a_s_valid = 4'b0100;
        a_m_ready = 1'b1;
        sb_a.push_back(mk(2, 8'hA1));
        cycle();
        a_s_valid = '0;
        chk("t1_m_valid", 32'(a_m_valid), 1);
        chk("t1_m_chan", 32'(a_m_chan), 2);
        chk("t1_m_value", 32'(a_m_value), 32'hA1);
        cycle();
        chk("t1_m_valid_after", 32'(a_m_valid), 0);
        chk("t1_m_value_idle", 32'(a_m_value), 0);

        // Two items per channel, drained round-robin from a fresh pointer
        do_reset();
        a_m_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++)
                a_s_value[c*8 +: 8] = 8'(c*16 + k + 1);
            a_s_valid = 4'hF;
            cycle();
        end
        a_s_valid = '0;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++)
                sb_a.push_back(mk(c, c*16 + k + 1));
        a_m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_m_valid", 32'(a_m_valid), 1);
            cycle();
        end
        chk("t2_m_valid_end", 32'(a_m_valid), 0);
        chk("t2_level_end", 32'(a_level), 0);

        // Fill channel 0 to DEPTH with output stalled
        a_m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_s_value[7:0] = 8'(8'h50 + i);
            a_s_valid = 4'b0001;
            chk("t3_s_ready", 32'(a_s_ready[0]), 32'(i < 5));
            chk("t3_level", 32'(lv(a_level, 0)), 32'(i));
            chk("t3_afull", 32'(a_afull[0]), 32'(i >= 4));
            if (i < 5)
                sb_a.push_back(mk(0, 8'h50 + i));
            cycle();
        end
        a_s_valid = '0;
        chk("t3_level_full", 32'(lv(a_level, 0)), 5);
        chk("t3_afull_full", 32'(a_afull[0]), 1);
        chk("t3_s_ready_full", 32'(a_s_ready[0]), 0);
        a_m_ready = 1'b1;
        repeat (5) cycle();
        chk("t3_drained_valid", 32'(a_m_valid), 0);
        chk("t3_drained_level", 32'(a_level), 0);

        // Stalled grant on ch3 must survive ch0 becoming eligible
        do_reset();
        a_m_ready = 1'b0;
        a_s_value[3*8 +: 8] = 8'hC3;
        a_s_valid = 4'b1000;
        sb_a.push_back(mk(3, 8'hC3));
        cycle();
        a_s_valid = '0;
        cycle();
        chk("t4_chan_before", 32'(a_m_chan), 3);
        chk("t4_value_before", 32'(a_m_value), 32'hC3);
        a_s_value[7:0] = 8'h0A;
        a_s_valid = 4'b0001;
        sb_a.push_back(mk(0, 8'h0A));
        cycle();
        a_s_valid = '0;
        cycle();
        chk("t4_lock_chan", 32'(a_m_chan), 3);
        chk("t4_lock_value", 32'(a_m_value), 32'hC3);
        a_m_ready = 1'b1;
        cycle();
        chk("t4_next_chan", 32'(a_m_chan), 0);
        chk("t4_next_value", 32'(a_m_value), 32'h0A);
        cycle();
        chk("t4_idle", 32'(a_m_valid), 0);

        // Flush ch1 with a simultaneous push (combinational output)
        a_m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_s_value[1*8 +: 8] = 8'(8'h11 + i);
            a_s_valid = 4'b0010;
            cycle();
        end
        chk("t5_level_pre", 32'(lv(a_level, 1)), 3);
        a_s_value[1*8 +: 8] = 8'hEE;
        a_s_valid = 4'b0010;
        a_flush = 4'b0010;
        cycle();
        a_s_valid = '0;
        a_flush = '0;
        chk("t5_level_post", 32'(lv(a_level, 1)), 0);
        chk("t5_m_valid_post", 32'(a_m_valid), 0);
        chk("t5_s_ready_post", 32'(a_s_ready[1]), 1);
        a_m_ready = 1'b1;
        cycle();
        chk("t5_nothing_out", 32'(a_m_valid), 0);

        // Flush ch1 while one ch1 item sits in the output register
        b_m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_s_value[1*8 +: 8] = 8'(8'hB0 + i);
            b_s_valid = 4'b0010;
            cycle();
        end
        sb_b.push_back(mk(1, 8'hB0));
        b_s_value[1*8 +: 8] = 8'hEE;
        b_s_valid = 4'b0010;
        b_flush = 4'b0010;
        cycle();
        b_s_valid = '0;
        b_flush = '0;
        chk("b5_level_post", 32'(lv(b_level, 1)), 0);
        chk("b5_m_valid_held", 32'(b_m_valid), 1);
        chk("b5_m_chan_held", 32'(b_m_chan), 1);
        chk("b5_m_value_held", 32'(b_m_value), 32'hB0);
        b_m_ready = 1'b1;
        cycle();
        chk("b5_m_valid_after", 32'(b_m_valid), 0);
        chk("b5_m_value_idle", 32'(b_m_value), 0);

        // Registered output sustains one item per cycle
        b_m_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            b_s_value[0*8 +: 8] = 8'(8'h60 + k);
            b_s_value[2*8 +: 8] = 8'(8'h80 + k);
            b_s_valid = 4'b0101;
            cycle();
        end
        b_s_valid = '0;
        sb_b.push_back(mk(2, 8'h80));
        sb_b.push_back(mk(0, 8'h60));
        sb_b.push_back(mk(2, 8'h81));
        sb_b.push_back(mk(0, 8'h61));
        b_m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("b6_m_valid", 32'(b_m_valid), 1);
            cycle();
        end
        chk("b6_m_valid_end", 32'(b_m_valid), 0);

        // Reset mid-stream with three items queued
        a_m_ready = 1'b0;
        a_s_value[23:0] = 24'h332211;
        a_s_valid = 4'b0111;
        cycle();
        a_s_valid = '0;
        cycle();
        chk("t6_pre_valid", 32'(a_m_valid), 1);
        reset = 1'b1;
        #2;
        chk("t6_rst_m_valid", 32'(a_m_valid), 0);
        chk("t6_rst_m_value", 32'(a_m_value), 0);
        chk("t6_rst_level", 32'(a_level), 0);
        chk("t6_rst_s_ready", 32'(a_s_ready), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("t6_rel_s_ready", 32'(a_s_ready), 32'hF);
        chk("t6_rel_m_valid", 32'(a_m_valid), 0);
        chk("t6_rel_level", 32'(a_level), 0);

        chk("sb_a_drained", 32'(sb_a.size()), 0);
        chk("sb_b_drained", 32'(sb_b.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
